// File: rtl/axis_noc_pkg.sv
// Shared types and helpers for the AXI-Stream shims around the double-ring NoC.
// Beat layout used by the muxes: {tdata, tlast, tdest, tid}, tid in the LSBs.
package axis_noc_pkg;

  localparam int DEF_TID_WIDTH   = 2;
  localparam int DEF_TDEST_WIDTH = 4;
  localparam int DEF_TDATA_WIDTH = 512;

  // Reference layout; modules with other widths declare a local twin with this field order.
  typedef struct packed {
    logic [DEF_TDATA_WIDTH-1:0] tdata;
    logic                       tlast;
    logic [DEF_TDEST_WIDTH-1:0] tdest;
    logic [DEF_TID_WIDTH-1:0]   tid;
  } axis_beat_t;

  // Index width that never collapses to zero bits, even for a single source.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry FIFO skid buffer with a registered ready: output fully registered,
// no combinational path from m_ready to s_ready, one beat per cycle sustained.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             in_ready_reg;
  logic             push;
  logic             pop;

  assign m_valid = (count_reg != 2'd0);
  assign m_data  = head_reg;
  assign s_ready = in_ready_reg;
  assign push    = s_valid & in_ready_reg;
  assign pop     = m_valid & m_ready;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (!push && pop) begin
      count_next = count_reg - 2'd1;
    end
  end

  // in_ready_reg only admits a push when at most one entry is held, so a push never meets a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= 2'd0;
      in_ready_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      in_ready_reg <= (count_next != 2'd2);
      if (pop && count_reg == 2'd2) begin
        head_reg <= tail_reg;
      end else if (push && (count_reg == 2'd0 || pop)) begin
        head_reg <= s_data;
      end else if (push) begin
        tail_reg <= s_data;
      end
    end
  end

endmodule

// File: rtl/axis_packet_mux.sv
// Packet-atomic round-robin merge of NUM_INPUTS AXI-Stream sources into one ring
// endpoint; the winning source index is stamped on tid, output via a skid buffer.
module axis_packet_mux
  import axis_noc_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid [NUM_INPUTS],
  output logic                   s_axis_tready [NUM_INPUTS],
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata  [NUM_INPUTS],
  input  logic                   s_axis_tlast  [NUM_INPUTS],
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest  [NUM_INPUTS],
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [TID_WIDTH-1:0]   m_axis_tid,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest
);

  localparam int IDX_W = clog2_min1(NUM_INPUTS);

  generate
    if (NUM_INPUTS < 1 || NUM_INPUTS > (1 << TID_WIDTH)) begin : g_bad_num_inputs
      $error("axis_packet_mux: NUM_INPUTS must be in 1..2**TID_WIDTH");
    end
  endgenerate

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TID_WIDTH-1:0]   tid;
  } beat_t;

  state_t state_reg, state_next;
  idx_t   rr_ptr_reg, rr_ptr_next;
  idx_t   lock_reg, lock_next;
  idx_t   grant_idx;
  logic   grant_found;
  idx_t   sel_idx;
  logic   sel_valid;
  logic   in_ready;
  logic   accept;
  beat_t  push_beat;
  beat_t  out_beat;

  function automatic idx_t wrap_idx(input idx_t base, input int off);
    int p;
    p = int'(base) + off;
    if (p >= NUM_INPUTS) p = p - NUM_INPUTS;
    return idx_t'(p);
  endfunction

  function automatic idx_t next_idx(input idx_t cur);
    return (cur == idx_t'(NUM_INPUTS - 1)) ? idx_t'(0) : cur + idx_t'(1);
  endfunction

  // Scan from the far end so the requester closest to rr_ptr is the last writer and wins.
  always_comb begin
    grant_idx   = rr_ptr_reg;
    grant_found = 1'b0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (s_axis_tvalid[wrap_idx(rr_ptr_reg, k)]) begin
        grant_idx   = wrap_idx(rr_ptr_reg, k);
        grant_found = 1'b1;
      end
    end
  end

  assign sel_idx   = (state_reg == LOCKED) ? lock_reg : grant_idx;
  assign sel_valid = (state_reg == LOCKED) ? s_axis_tvalid[lock_reg] : grant_found;
  assign accept    = sel_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
      assign s_axis_tready[gi] = in_ready & (sel_idx == idx_t'(gi))
                               & ((state_reg == LOCKED) | grant_found);
    end
  endgenerate

  always_comb begin
    push_beat.tdata = s_axis_tdata[sel_idx];
    push_beat.tlast = s_axis_tlast[sel_idx];
    push_beat.tdest = s_axis_tdest[sel_idx];
    push_beat.tid   = TID_WIDTH'(sel_idx);
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    lock_next   = lock_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (s_axis_tlast[sel_idx]) begin
            rr_ptr_next = next_idx(sel_idx);
          end else begin
            lock_next  = sel_idx;
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        // A bubble from the locked source simply waits here; nobody else may cut in.
        if (accept && s_axis_tlast[sel_idx]) begin
          rr_ptr_next = next_idx(sel_idx);
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      lock_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      lock_reg   <= lock_next;
    end
  end

  axis_skid_buffer #(
    .WIDTH($bits(beat_t))
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (sel_valid),
    .s_ready (in_ready),
    .s_data  (push_beat),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (out_beat)
  );

  assign m_axis_tdata = out_beat.tdata;
  assign m_axis_tlast = out_beat.tlast;
  assign m_axis_tdest = out_beat.tdest;
  assign m_axis_tid   = out_beat.tid;

endmodule

// File: tb/tb_axis_packet_mux.sv
// Directed bench for axis_packet_mux: per-source beat queues feed the DUT, a
// negedge monitor captures merged output beats, each task checks its scenario.
module tb_axis_packet_mux;

  localparam int N    = 4;
  localparam int TW   = 2;
  localparam int DW   = 4;
  localparam int DATW = 512;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid [N];
  logic            s_ready [N];
  logic [DATW-1:0] s_data  [N];
  logic            s_last  [N];
  logic [DW-1:0]   s_dest  [N];
  logic            m_valid;
  logic            m_ready;
  logic [DATW-1:0] m_data;
  logic            m_last;
  logic [TW-1:0]   m_tid;
  logic [DW-1:0]   m_dest;

  axis_packet_mux #(
    .NUM_INPUTS(N), .TID_WIDTH(TW), .TDEST_WIDTH(DW), .TDATA_WIDTH(DATW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_tdest(s_dest),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tlast(m_last), .m_axis_tid(m_tid), .m_axis_tdest(m_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic          last;
    logic [DW-1:0] dest;
  } in_beat_t;

  typedef struct {
    logic [TW-1:0]   tid;
    logic [DATW-1:0] data;
    logic            last;
    logic [DW-1:0]   dest;
    int              cyc;
  } out_beat_t;

  in_beat_t  src_q [N][$];
  out_beat_t out_q [$];
  bit        hold  [N];
  bit        fired [N];
  bit        bp_mode;
  int        bp_phase;
  int        cyc;
  int        total;
  int        bad;

  // Source driver: applies inputs 1 time unit after each rising edge.
  initial begin
    for (int i = 0; i < N; i++) begin
      s_valid[i] = 1'b0; s_data[i] = '0; s_last[i] = 1'b0; s_dest[i] = '0;
      hold[i] = 1'b0; fired[i] = 1'b0;
    end
    m_ready = 1'b1;
    bp_mode = 1'b0; bp_phase = 0; cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        fired[i] = 1'b0;
        if (src_q[i].size() > 0 && !hold[i]) begin
          s_valid[i] = 1'b1;
          s_data[i]  = DATW'(src_q[i][0].data);
          s_last[i]  = src_q[i][0].last;
          s_dest[i]  = src_q[i][0].dest;
        end else begin
          s_valid[i] = 1'b0;
        end
      end
      if (bp_mode) begin
        m_ready  = (bp_phase % 4 == 0) || (bp_phase % 4 == 3);
        bp_phase++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Handshake monitor on the falling edge, where all signals are settled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) if (s_valid[i] && s_ready[i]) fired[i] = 1'b1;
        if (m_valid && m_ready) out_q.push_back('{m_tid, m_data, m_last, m_dest, cyc});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_out(input int n, input int max_cyc, output bit ok);
    int c;
    c = 0;
    while (out_q.size() < n && c < max_cyc) begin
      tick();
      c++;
    end
    ok = (out_q.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    src_q[3].push_back('{32'h3A, 1'b1, 4'h5});
    repeat (3) begin
      tick();
      total++;
      if (s_ready[0] !== 1'b0 || s_ready[1] !== 1'b0 || s_ready[2] !== 1'b0 || s_ready[3] !== 1'b0) begin
        $display("FAIL reset_ready: got %b%b%b%b, required 0000", s_ready[3], s_ready[2], s_ready[1], s_ready[0]);
        bad++;
      end
      total++;
      if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || m_tid !== '0 || m_dest !== '0) begin
        $display("FAIL reset_out: valid=%b tid=%0d last=%b dest=%0d, required all zero", m_valid, m_tid, m_last, m_dest);
        bad++;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    total++;
    if (s_ready[3] !== 1'b0) begin
      $display("FAIL release_ready_early: got %b, required 0 before first edge", s_ready[3]);
      bad++;
    end
    tick();
    total++;
    if (s_ready[3] !== 1'b1 || s_ready[0] !== 1'b0 || m_valid !== 1'b0) begin
      $display("FAIL release_ready: ready3=%b ready0=%b m_valid=%b, required 1 0 0", s_ready[3], s_ready[0], m_valid);
      bad++;
    end
    wait_out(1, 20, ok);
    total++;
    if (!ok || out_q[0].tid !== 2'd3 || out_q[0].data !== DATW'(32'h3A) || out_q[0].last !== 1'b1 || out_q[0].dest !== 4'h5) begin
      $display("FAIL reset_first_beat: ok=%0d size=%0d, required tid=3 data=3a last=1 dest=5", ok, out_q.size());
      bad++;
    end
    tick(); tick();
    repeat (3) begin
      tick();
      total++;
      if (m_valid !== 1'b0) begin
        $display("FAIL idle_valid: got %b, required 0", m_valid);
        bad++;
      end
    end
    out_q.delete();
  endtask

  task automatic test_round_robin();
    bit ok;
    int p;
    logic [31:0] ed;
    for (int s = 0; s < N; s++)
      for (int r = 0; r < 2; r++)
        for (int b = 0; b < 3; b++)
          src_q[s].push_back('{32'(s * 256 + r * 3 + b), (b == 2), 4'(s * 3 + 1)});
    wait_out(24, 200, ok);
    total++;
    if (!ok) begin
      $display("FAIL rr_count: got %0d beats, required 24", out_q.size());
      bad++;
    end else begin
      for (int k = 0; k < 24; k++) begin
        p  = k / 3;
        ed = 32'((p % 4) * 256 + (p / 4) * 3 + k % 3);
        total++;
        if (out_q[k].tid !== 2'(p % 4) || out_q[k].data !== DATW'(ed) || out_q[k].last !== (k % 3 == 2)
            || out_q[k].dest !== 4'((p % 4) * 3 + 1)) begin
          $display("FAIL rr_beat%0d: tid=%0d data=%0h last=%b, required tid=%0d data=%0h last=%b",
                   k, out_q[k].tid, out_q[k].data[31:0], out_q[k].last, p % 4, ed, (k % 3 == 2));
          bad++;
        end
        if (k > 0) begin
          total++;
          if (out_q[k].cyc !== out_q[k-1].cyc + 1) begin
            $display("FAIL rr_gap%0d: cycle %0d after %0d, required consecutive", k, out_q[k].cyc, out_q[k-1].cyc);
            bad++;
          end
        end
      end
    end
    tick(); tick();
    out_q.delete();
  endtask

  task automatic test_atomicity();
    bit ok;
    int c;
    logic [TW-1:0] etid [5];
    logic [31:0]   edat [5];
    etid = '{2, 2, 2, 3, 0};
    edat = '{32'h200, 32'h201, 32'h202, 32'h3BB, 32'h0AA};
    for (int b = 0; b < 3; b++) src_q[2].push_back('{32'(32'h200 + b), (b == 2), 4'h2});
    c = 0;
    while (!fired[2] && c < 20) begin
      tick();
      c++;
    end
    total++;
    if (!fired[2]) begin
      $display("FAIL atom_first_accept: got no handshake, required source 2 accepted");
      bad++;
    end
    hold[2] = 1'b1;
    src_q[0].push_back('{32'h0AA, 1'b1, 4'h0});
    src_q[3].push_back('{32'h3BB, 1'b1, 4'h3});
    repeat (5) begin
      tick();
      total++;
      if (s_ready[0] !== 1'b0 || s_ready[3] !== 1'b0 || out_q.size() > 1) begin
        $display("FAIL atom_bubble: ready0=%b ready3=%b beats=%0d, required 0 0 <=1", s_ready[0], s_ready[3], out_q.size());
        bad++;
      end
    end
    hold[2] = 1'b0;
    wait_out(5, 50, ok);
    total++;
    if (!ok) begin
      $display("FAIL atom_count: got %0d beats, required 5", out_q.size());
      bad++;
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (out_q[k].tid !== etid[k] || out_q[k].data !== DATW'(edat[k])) begin
          $display("FAIL atom_beat%0d: tid=%0d data=%0h, required tid=%0d data=%0h",
                   k, out_q[k].tid, out_q[k].data[31:0], etid[k], edat[k]);
          bad++;
        end
      end
    end
    tick(); tick();
    out_q.delete();
  endtask

  task automatic test_backpressure();
    int  occ;
    int  c;
    bit  stalled;
    bp_phase = 0;
    bp_mode  = 1'b1;
    for (int b = 0; b < 32; b++) src_q[1].push_back('{32'(b), (b == 31), 4'h9});
    occ = 0; c = 0; stalled = 1'b0;
    while (out_q.size() < 32 && c < 300) begin
      tick();
      c++;
      total++;
      if (m_valid !== (occ != 0)) begin
        $display("FAIL bp_valid: got %b with %0d held, required %b", m_valid, occ, (occ != 0));
        bad++;
      end
      if (s_valid[1]) begin
        total++;
        if (s_ready[1] !== (occ <= 1)) begin
          $display("FAIL bp_ready: got %b with %0d held, required %b", s_ready[1], occ, (occ <= 1));
          bad++;
        end
        if (!s_ready[1]) stalled = 1'b1;
      end
      occ = occ + ((s_valid[1] && s_ready[1]) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end
    bp_mode = 1'b0;
    total++;
    if (out_q.size() != 32 || !stalled) begin
      $display("FAIL bp_count: got %0d beats stalled=%0d, required 32 beats stalled=1", out_q.size(), stalled);
      bad++;
    end else begin
      for (int k = 0; k < 32; k++) begin
        total++;
        if (out_q[k].tid !== 2'd1 || out_q[k].data !== DATW'(k) || out_q[k].last !== (k == 31)) begin
          $display("FAIL bp_beat%0d: tid=%0d data=%0h last=%b, required tid=1 data=%0h last=%b",
                   k, out_q[k].tid, out_q[k].data[31:0], out_q[k].last, k, (k == 31));
          bad++;
        end
      end
    end
    tick(); tick(); tick();
    out_q.delete();
  endtask

  task automatic test_single_beat();
    bit ok;
    logic [TW-1:0] et;
    logic [31:0]   ed;
    for (int j = 0; j < 4; j++) begin
      src_q[1].push_back('{32'(32'h100 + j), 1'b1, 4'h1});
      src_q[3].push_back('{32'(32'h300 + j), 1'b1, 4'h3});
    end
    wait_out(8, 60, ok);
    total++;
    if (!ok) begin
      $display("FAIL single_count: got %0d beats, required 8", out_q.size());
      bad++;
    end else begin
      for (int k = 0; k < 8; k++) begin
        et = (k % 2 == 0) ? 2'd3 : 2'd1;
        ed = 32'(((k % 2 == 0) ? 32'h300 : 32'h100) + k / 2);
        total++;
        if (out_q[k].tid !== et || out_q[k].data !== DATW'(ed) || out_q[k].last !== 1'b1) begin
          $display("FAIL single_beat%0d: tid=%0d data=%0h, required tid=%0d data=%0h",
                   k, out_q[k].tid, out_q[k].data[31:0], et, ed);
          bad++;
        end
      end
    end
    tick(); tick();
    out_q.delete();
  endtask

  task automatic test_async_reset();
    bit ok;
    for (int b = 0; b < 8; b++) src_q[0].push_back('{32'(b), (b == 7), 4'h0});
    wait_out(2, 30, ok);
    total++;
    if (!ok || m_valid !== 1'b1) begin
      $display("FAIL arst_pre: beats=%0d m_valid=%b, required >=2 and 1", out_q.size(), m_valid);
      bad++;
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || m_data !== '0 || s_ready[0] !== 1'b0) begin
      $display("FAIL arst_drop: m_valid=%b ready0=%b, required 0 0", m_valid, s_ready[0]);
      bad++;
    end
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      fired[i] = 1'b0;
    end
    out_q.delete();
    src_q[3].push_back('{32'h3DD, 1'b1, 4'h3});
    src_q[1].push_back('{32'h1CC, 1'b1, 4'h1});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_out(2, 30, ok);
    repeat (5) tick();
    total++;
    if (!ok || out_q.size() != 2) begin
      $display("FAIL arst_count: got %0d beats, required 2", out_q.size());
      bad++;
    end else begin
      total++;
      if (out_q[0].tid !== 2'd1 || out_q[0].data !== DATW'(32'h1CC) || out_q[1].tid !== 2'd3
          || out_q[1].data !== DATW'(32'h3DD)) begin
        $display("FAIL arst_order: tids=%0d,%0d, required 1,3", out_q[0].tid, out_q[1].tid);
        bad++;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    total = 0;
    bad   = 0;
    test_reset();
    test_round_robin();
    test_atomicity();
    test_backpressure();
    test_single_beat();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_mux.md
Name: axis_packet_mux

Overview:
- Merges NUM_INPUTS user AXI-Stream sources into one ring endpoint input (axis_in_* of one router port of the double-ring NoC top).
- Arbitration is round-robin and packet-atomic: once a source wins, its whole packet (through tlast) passes before any other source is granted.
- Stamps the winning source index onto tid, so the destination can demultiplex per source.
- Output is fully registered through a 2-entry skid buffer: full throughput, no combinational ready path from m_axis_tready to s_axis_tready.

Parameters:
- NUM_INPUTS, 4, number of upstream sources; must be ≥1 and ≤ 2**TID_WIDTH, otherwise elaboration error.
- TID_WIDTH, 2, width of m_axis_tid; carries the source index.
- TDEST_WIDTH, 4, destination width; passed through unchanged.
- TDATA_WIDTH, 512, data width; passed through unchanged.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1 [NUM_INPUTS]  per-source valid.
- s_axis_tready  out  1 [NUM_INPUTS]  per-source ready.
- s_axis_tdata  in  TDATA_WIDTH [NUM_INPUTS]  per-source data.
- s_axis_tlast  in  1 [NUM_INPUTS]  per-source end of packet.
- s_axis_tdest  in  TDEST_WIDTH [NUM_INPUTS]  per-source destination.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  merged ready.
- m_axis_tdata  out  TDATA_WIDTH  merged data.
- m_axis_tlast  out  1  merged end of packet.
- m_axis_tid  out  TID_WIDTH  index of the source that sent the beat.
- m_axis_tdest  out  TDEST_WIDTH  destination, passed through.

Behaviour:
- Reset (async assert, released on a clk edge):
  - state=IDLE, rr_ptr=0, skid empty, in_ready register=0.
  - m_axis_tvalid=0; m_axis_tdata/tlast/tid/tdest=0.
  - All s_axis_tready=0 while in reset. in_ready becomes 1 on the first clk edge after release.
- Reset mid-packet: all state and skid contents are discarded; the partial packet is lost. Upstream is responsible for re-sending.
- in_ready: registered, =1 when the skid holds ≤1 entry after the current cycle's pop/push.
- IDLE:
  - grant = first i with s_axis_tvalid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_INPUTS. Grant is combinational.
  - s_axis_tready[grant]=in_ready; every other s_axis_tready=0.
  - Accepted beat, tlast=0: lock = grant, go to LOCKED.
  - Accepted beat, tlast=1 (single-beat packet): rr_ptr = grant+1 mod N, stay IDLE.
  - No valid: no change.
- LOCKED:
  - Only s_axis_tready[lock]=in_ready; all others 0. Other sources' valids are ignored.
  - Accepted beat with tlast=1: rr_ptr = lock+1 mod N, go to IDLE.
  - Locked source deasserting valid mid-packet (bubble): hold LOCKED indefinitely; no other source is granted.
- Accepted beat is pushed as {tdata, tlast, tdest, tid=source index zero-extended to TID_WIDTH}.
- Latency: a beat accepted in cycle t presents on m_axis in cycle t+1 at earliest.
- Skid buffer:
  - 2 entries, FIFO order.
  - m_axis_tvalid = skid non-empty; m_axis_* = head entry.
  - Pop on m_axis_tvalid & m_axis_tready.
  - Simultaneous push and pop with 1 entry: count stays 1, head advances.
  - Full (2 entries): in_ready=0 in the next cycle. No beat is ever dropped or duplicated.
- Throughput: with m_axis_tready=1 continuously, one beat per cycle, including back-to-back packets from different sources (no idle cycle at a packet boundary).
- NUM_INPUTS=1: degenerates to a registered pipe with tid=0.

Decomposition:
- Shared package axis_noc_pkg holds:
  - a parameterised beat struct typedef {tdata, tlast, tdest, tid};
  - a function clog2_min1 used for index widths.
- One sub-module, axis_skid_buffer: 2-entry, registered ready, async active-high reset. It is reusable by the other shims.
- The round-robin arbiter and FSM stay inline.

Test Plan:
1. Reset then idle: hold rst 3 cycles, release → all s_axis_tready=0 in reset, =1 for the granted requester from the 1st post-release cycle; m_axis_tvalid=0 throughout with no input.
2. Round-robin with full contention: all 4 sources send 3-beat packets continuously, m_axis_tready=1 → tid order 0,0,0,1,1,1,2,2,2,3,3,3,0…; 12 beats in 12 consecutive cycles.
3. Packet atomicity: source 2 sends beat 1, drops valid 5 cycles while source 0 is valid → no source-0 beat appears until source 2's tlast; then source 3 (next after 2) wins if valid, else source 0.
4. Backpressure: m_axis_tready toggles 1,0,0,1 repeating with source 1 streaming data 0..31 → m_axis_tdata sequence is exactly 0..31 with tid=1; s_axis_tready[1] falls one cycle after the skid fills.
5. Single-beat packets: sources 1 and 3 both valid with tlast=1 and rr_ptr=2 → order 3,1,3,1…; rr_ptr advances each beat.
6. Async reset mid-packet: assert rst between edges during a source-0 packet → m_axis_tvalid drops immediately; after release the first grant goes to the lowest valid index ≥0.
